cvbs_mixer: RTL

CVBS_MIXER -- requirements
Module: cvbs_mixer

---
 rtl/cvbs_pkg.sv | 55 +++++
 rtl/cvbs_sat.sv | 24 ++
 rtl/cvbs_mixer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cvbs_pkg.sv
//-----------------------------------------------------------------------------
// cvbs_pkg
// Shared types and default constants for the composite video (CVBS) mixer.
//   - cvbs_state_e : line-timing FSM states
//   - s1_t / s2_t  : pipeline stage payloads
//   - default DAC levels, luma gain, chroma zero, sync/burst timing
//   - sext9()      : sign-extends a 9-bit chroma offset to the 11-bit sum width
//-----------------------------------------------------------------------------
package cvbs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_POST_SYNC = 3'd2,
        ST_BLANK     = 3'd3,
        ST_ACTIVE    = 3'd4
    } cvbs_state_e;

    // Default DAC codes and scaling
    localparam logic [7:0]  BLANK_LEVEL = 8'd72;
    localparam logic [7:0]  SYNC_LEVEL  = 8'd4;
    localparam logic [7:0]  LUMA_GAIN   = 8'd180;
    localparam logic [7:0]  C_ZERO      = 8'd100;

    // Default sync / burst timing, in clk cycles
    localparam logic [10:0] BROAD_MIN   = 11'd1000;
    localparam logic [8:0]  BURST_END   = 9'd180;

    // Legal DAC range outside bypass; 0 and 255 stay reserved for the DAC
    localparam logic [7:0]  SAT_MIN     = 8'd1;
    localparam logic [7:0]  SAT_MAX     = 8'd254;

    // S1: registered copy of every input
    typedef struct packed {
        logic       enable;
        logic       csync;
        logic       hblank;
        logic       vblank;
        logic [7:0] y;
        logic [7:0] c;
    } s1_t;

    // S2: scaled luma, signed chroma offset (two's complement in 9 bits),
    // and raw luma for bypass
    typedef struct packed {
        logic [7:0] y;
        logic [7:0] luma;
        logic [8:0] chroma;
    } s2_t;

    function automatic logic [10:0] sext9(input logic [8:0] v);
        return {{2{v[8]}}, v};
    endfunction

endpackage

// File: rtl/cvbs_sat.sv
//-----------------------------------------------------------------------------
// cvbs_sat
// Clamps the 11-bit signed composite sum into the DAC range [1,254].
// Ports:
//   sum_in  in  11  signed composite sum
//   sat_out out  8  clamped DAC code
//-----------------------------------------------------------------------------
module cvbs_sat (
    input  logic signed [10:0] sum_in,
    output logic        [7:0]  sat_out
);
    import cvbs_pkg::*;

    always_comb begin
        if (sum_in < $signed({3'b000, SAT_MIN})) begin
            sat_out = SAT_MIN;
        end else if (sum_in > $signed({3'b000, SAT_MAX})) begin
            sat_out = SAT_MAX;
        end else begin
            sat_out = sum_in[7:0];
        end
    end

endmodule

// File: rtl/cvbs_mixer.sv
//-----------------------------------------------------------------------------
// cvbs_mixer
// Mixes luma, chroma (with embedded burst) and sync/blanking timing into an
// 8-bit composite DAC code. Three-stage pipeline, input to cvbs = 3 clk:
//   S1  registers every input
//   S2  scales luma, removes chroma offset; the line FSM state lives here,
//       computed from S1 controls so it stays aligned with the S2 data
//   S3  forms the per-state sum, saturates it and registers cvbs
// Ports:
//   clk         in   1  mixer clock
//   reset       in   1  asynchronous, active-high
//   enable      in   1  1 = composite mix, 0 = luma bypass
//   y_in        in   8  luma, unsigned
//   c_in        in   8  chroma, offset-binary around C_ZERO
//   csync       in   1  composite sync, active-high
//   hblank      in   1  horizontal blanking, active-high
//   vblank      in   1  vertical blanking, active-high
//   cvbs        out  8  composite DAC code (registered)
//   broad_sync  out  1  set by a broad (vertical) sync pulse, held to the
//                       next sync falling edge (registered, aligned to cvbs)
//-----------------------------------------------------------------------------
module cvbs_mixer #(
    parameter logic [7:0]  BLANK_LEVEL = cvbs_pkg::BLANK_LEVEL,
    parameter logic [7:0]  SYNC_LEVEL  = cvbs_pkg::SYNC_LEVEL,
    parameter logic [7:0]  LUMA_GAIN   = cvbs_pkg::LUMA_GAIN,
    parameter logic [7:0]  C_ZERO      = cvbs_pkg::C_ZERO,
    parameter logic [10:0] BROAD_MIN   = cvbs_pkg::BROAD_MIN,
    parameter logic [8:0]  BURST_END   = cvbs_pkg::BURST_END
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] y_in,
    input  logic [7:0] c_in,
    input  logic       csync,
    input  logic       hblank,
    input  logic       vblank,
    output logic [7:0] cvbs,
    output logic       broad_sync
);
    import cvbs_pkg::*;

    //-------------------------------------------------------------------------
    // S1: input registers plus the previous csync sample for edge detection
    //-------------------------------------------------------------------------
    s1_t  s1_d, s1_q;
    logic csync_prev_d, csync_prev_q;

    // NOTE: every signal assigned in an always_comb gets a value on every
    // path (here trivially, elsewhere via a default first) so no latch is
    // inferred.
    always_comb begin
        s1_d = '{enable: enable, csync: csync, hblank: hblank,
                 vblank: vblank, y: y_in, c: c_in};
        csync_prev_d = s1_q.csync;
    end

    // NOTE: flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= '0;
            csync_prev_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            csync_prev_q <= csync_prev_d;
        end
    end

    //-------------------------------------------------------------------------
    // Line FSM, evaluated on S1 controls. Its state register is clocked on
    // the same edge as the S2 data registers, so state_q always describes
    // the sample sitting in S2.
    //-------------------------------------------------------------------------
    cvbs_state_e state_d, state_q;
    logic [10:0] width_d, width_q;     // sync pulse width, saturating
    logic [8:0]  post_d,  post_q;      // cycles since sync fall
    logic        broad_d, broad_q;     // last sync pulse was broad
    logic        locked_d, locked_q;   // a sync edge has been seen since reset
    logic        cs_rise, cs_fall, blanked;

    always_comb begin
        cs_rise = s1_q.csync & ~csync_prev_q;
        cs_fall = ~s1_q.csync & csync_prev_q;
        blanked = s1_q.hblank | s1_q.vblank;

        // Line phase is unknown after reset: stay at blanking level until the
        // first csync rise re-establishes timing.
        state_d = state_q;
        if (!locked_q && !cs_rise) begin
            state_d = ST_BLANK;
        end else if (!s1_q.enable) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            state_d = s1_q.csync ? ST_SYNC : ST_BLANK;
        end else if (cs_rise) begin
            // A new sync edge wins over every other transition, including a
            // blanking release in the same cycle or a burst still in progress.
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (cs_fall) state_d = ST_POST_SYNC;
                end
                ST_POST_SYNC: begin
                    if (post_q == BURST_END) state_d = blanked ? ST_BLANK : ST_ACTIVE;
                end
                ST_BLANK: begin
                    if (!blanked) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (blanked) state_d = ST_BLANK;
                end
                default: state_d = ST_BLANK;
            endcase
        end

        // Width counts the sync-high samples, so at the falling edge it
        // equals the pulse length in cycles.
        if (state_d != ST_SYNC) begin
            width_d = '0;
        end else if (state_q != ST_SYNC) begin
            width_d = 11'd1;
        end else if (width_q != '1) begin
            width_d = width_q + 11'd1;
        end else begin
            width_d = width_q;
        end

        // Burst window counter runs only while staying in POST_SYNC; any exit
        // (end of window, new sync, bypass) clears it.
        if (state_d == ST_POST_SYNC && state_q == ST_POST_SYNC) begin
            post_d = post_q + 9'd1;
        end else begin
            post_d = '0;
        end

        // Broad/narrow decision is taken only at the sync falling edge and
        // held until the next one.
        broad_d = broad_q;
        if (state_q == ST_SYNC && state_d == ST_POST_SYNC) begin
            broad_d = (width_q >= BROAD_MIN);
        end

        locked_d = locked_q | cs_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_BLANK;
            width_q  <= '0;
            post_q   <= '0;
            broad_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            post_q   <= post_d;
            broad_q  <= broad_d;
            locked_q <= locked_d;
        end
    end

    //-------------------------------------------------------------------------
    // S2: luma scaling and chroma offset removal
    //-------------------------------------------------------------------------
    s2_t s2_d, s2_q;

    always_comb begin
        s2_d.y      = s1_q.y;
        s2_d.luma   = 8'((16'(s1_q.y) * 16'(LUMA_GAIN)) >> 8);
        s2_d.chroma = {1'b0, s1_q.c} - {1'b0, C_ZERO};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_q <= '0;
        end else begin
            s2_q <= s2_d;
        end
    end

    //-------------------------------------------------------------------------
    // S3: per-state sum, saturation, output registers
    //-------------------------------------------------------------------------
    logic signed [10:0] sum;
    logic [7:0]         sat;
    logic [7:0]         cvbs_d, cvbs_q;
    logic               broad_out_d, broad_out_q;

    always_comb begin
        case (state_q)
            ST_SYNC: begin
                sum = {3'b000, SYNC_LEVEL};
            end
            ST_POST_SYNC: begin
                // Burst is suppressed on lines that follow a broad pulse.
                sum = broad_q ? {3'b000, BLANK_LEVEL}
                              : {3'b000, BLANK_LEVEL} + sext9(s2_q.chroma);
            end
            ST_ACTIVE: begin
                sum = {3'b000, BLANK_LEVEL} + {3'b000, s2_q.luma} + sext9(s2_q.chroma);
            end
            default: begin
                sum = {3'b000, BLANK_LEVEL};
            end
        endcase

        // Bypass passes raw luma, including the reserved codes 0 and 255.
        cvbs_d      = (state_q == ST_IDLE) ? s2_q.y : sat;
        broad_out_d = broad_q;
    end

    cvbs_sat u_sat (
        .sum_in  (sum),
        .sat_out (sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cvbs_q      <= BLANK_LEVEL;
            broad_out_q <= 1'b0;
        end else begin
            cvbs_q      <= cvbs_d;
            broad_out_q <= broad_out_d;
        end
    end

    assign cvbs       = cvbs_q;
    assign broad_sync = broad_out_q;

endmodule
